// File: rtl/proj1.sv
// Registered two's-complement ALU: ADD/SUB/SHL/SHR/AND/OR/XOR/XNOR with V/C/N/Z flags.
// Build option: PROJ1_SATURATE_EN clamps overflowing ADD/SUB/SHL results instead of wrapping.
module proj1 #(
    parameter int WIDTH = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_arg0,
    input  logic [WIDTH-1:0] i_arg1,
    input  logic [2:0]       i_oper,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result,
    output logic [3:0]       o_flag
);

    // Handshake: an operation is taken on every rising edge where i_valid is high
    // (no ready/backpressure); o_valid pulses exactly one cycle later, and while it
    // is low o_result/o_flag keep the last result.

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_SHL  = 3'd2,
        OP_SHR  = 3'd3,
        OP_AND  = 3'd4,
        OP_OR   = 3'd5,
        OP_XOR  = 3'd6,
        OP_XNOR = 3'd7
    } op_t;

    // Left shifts are evaluated 16 bits wider so a 4-bit amount can never lose bits.
    localparam int EXT = 16;
    localparam int XW  = WIDTH + EXT;

`ifdef PROJ1_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    logic [3:0]              shamt;
    logic [WIDTH:0]          sum;
    logic [WIDTH:0]          diff;
    logic [WIDTH:0]          shl_z;
    logic signed [XW-1:0]    shl_s;
    logic signed [XW-1:0]    shl_chk;
    logic signed [WIDTH:0]   shr_x;
    logic [WIDTH-1:0]        res;
    logic                    c;
    logic                    v;

    always_comb begin
        shamt   = i_arg1[3:0];
        sum     = {1'b0, i_arg0} + {1'b0, i_arg1};
        diff    = {1'b0, i_arg0} - {1'b0, i_arg1};
        // Bit WIDTH of the zero-extended shift is the last bit pushed out (0 once s > WIDTH).
        shl_z   = {1'b0, i_arg0} << shamt;
        shl_s   = $signed({{EXT{i_arg0[WIDTH-1]}}, i_arg0}) <<< shamt;
        shl_chk = {{EXT{shl_s[WIDTH-1]}}, shl_s[WIDTH-1:0]};
        // A guard bit below the LSB catches the last bit shifted out to the right.
        shr_x   = $signed({i_arg0, 1'b0}) >>> shamt;

        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (op_t'(i_oper))
            OP_ADD: begin
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (i_arg0[WIDTH-1] == i_arg1[WIDTH-1]) && (res[WIDTH-1] != i_arg0[WIDTH-1]);
            end
            OP_SUB: begin
                res = diff[WIDTH-1:0];
                c   = diff[WIDTH];
                v   = (i_arg0[WIDTH-1] != i_arg1[WIDTH-1]) && (res[WIDTH-1] != i_arg0[WIDTH-1]);
            end
            OP_SHL: begin
                res = shl_z[WIDTH-1:0];
                c   = shl_z[WIDTH];
                v   = (shl_s != shl_chk);
            end
            OP_SHR: begin
                res = shr_x[WIDTH:1];
                c   = shr_x[0];
            end
            OP_AND:  res = i_arg0 & i_arg1;
            OP_OR:   res = i_arg0 | i_arg1;
            OP_XOR:  res = i_arg0 ^ i_arg1;
            default: res = ~(i_arg0 ^ i_arg1);
        endcase

`ifdef PROJ1_SATURATE_EN
        // Only ADD/SUB/SHL raise V, and in each case the true result carries A's sign.
        if (v) begin
            res = i_arg0[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid  <= 1'b0;
            o_result <= '0;
            o_flag   <= '0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_result <= res;
                o_flag   <= {v, c, res[WIDTH-1], (res == '0)};
            end
        end
    end

endmodule

// File: tb/tb_proj1.sv
// Bench for proj1: directed vector table, hand-written reset/hold sequences, and
// randomized back-to-back traffic against an integer-arithmetic reference model.
module tb_proj1;

    localparam int W = 10;
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_SHL = 3'd2, OP_SHR = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4, OP_OR = 3'd5, OP_XOR = 3'd6, OP_XNOR = 3'd7;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         o_valid;
    logic [W-1:0] o_result;
    logic [3:0]   o_flag;

    int n_vec  = 0;
    int n_miss = 0;

    logic [W+4:0] exp_q[$];

    typedef struct {
        logic [2:0] op;
        int         a;
        int         b;
        int         er;
        logic [3:0] ef;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    proj1 #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (valid),
        .i_arg0  (a),
        .i_arg1  (b),
        .i_oper  (op),
        .o_valid (o_valid),
        .o_result(o_result),
        .o_flag  (o_flag)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, expv, expv);
        end
    endtask

    task automatic chk_out(input string nm, input logic ev, input logic [W-1:0] er, input logic [3:0] ef);
        chk({nm, ".valid"}, {31'd0, o_valid}, {31'd0, ev});
        chk({nm, ".result"}, {{(32-W){1'b0}}, o_result}, {{(32-W){1'b0}}, er});
        chk({nm, ".flag"}, {28'd0, o_flag}, {28'd0, ef});
    endtask

    // Reference model from the arithmetic definitions: true value, range check, bit picks.
    function automatic logic [W+3:0] model(input logic [2:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb);
        longint sa = $signed(ma);
        longint sb = $signed(mb);
        longint ua = ma;
        longint ub = mb;
        longint lo = -(longint'(1) << (W - 1));
        longint hi = (longint'(1) << (W - 1)) - 1;
        int     s  = int'(mb[3:0]);
        longint tr = 0;
        logic [W-1:0] r = '0;
        logic c = 1'b0;
        logic v = 1'b0;
        case (mop)
            OP_ADD: begin
                tr = sa + sb; r = W'(tr);
                c = (ua + ub) >= (longint'(1) << W);
                v = (tr < lo) || (tr > hi);
            end
            OP_SUB: begin
                tr = sa - sb; r = W'(tr);
                c = ua < ub;
                v = (tr < lo) || (tr > hi);
            end
            OP_SHL: begin
                tr = sa * (longint'(1) << s);
                v = (tr < lo) || (tr > hi);
                r = (s >= W) ? '0 : W'(ua << s);
                c = (s == 0 || s > W) ? 1'b0 : 1'((ua >> (W - s)) & 1);
            end
            OP_SHR: begin
                r = (s >= W) ? (sa < 0 ? '1 : '0) : W'(sa >>> s);
                c = (s == 0) ? 1'b0 : (s >= W) ? ma[W-1] : 1'((ua >> (s - 1)) & 1);
            end
            OP_AND:  r = ma & mb;
            OP_OR:   r = ma | mb;
            OP_XOR:  r = ma ^ mb;
            default: r = ~(ma ^ mb);
        endcase
`ifdef PROJ1_SATURATE_EN
        if (v) r = (tr < 0) ? W'(lo) : W'(hi);
`endif
        return {v, c, r[W-1], (r == '0), r};
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return W'(511);
            1: return W'(-512);
            2: return '0;
            3: return '1;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1; valid = 1'b0; a = '0; b = '0; op = '0;

        // Table: values derived by hand from the operation rules.
        tbl.push_back('{OP_ADD,   64,   16,   80, 4'b0000});
        tbl.push_back('{OP_SUB,   64,   16,   48, 4'b0000});
        tbl.push_back('{OP_SHL,   64,   16,   64, 4'b0000});
        tbl.push_back('{OP_SHR,   64,   16,   64, 4'b0000});
        tbl.push_back('{OP_AND,   64,   16,    0, 4'b0001});
        tbl.push_back('{OP_OR,    64,   16,   80, 4'b0000});
        tbl.push_back('{OP_XOR,   64,   16,   80, 4'b0000});
        tbl.push_back('{OP_XNOR,  64,   16,  -81, 4'b0010});
`ifdef PROJ1_SATURATE_EN
        tbl.push_back('{OP_ADD,  511,  511,  511, 4'b1000});
        tbl.push_back('{OP_ADD, -511, -511, -512, 4'b1110});
        tbl.push_back('{OP_SUB,  511, -511,  511, 4'b1100});
        tbl.push_back('{OP_SUB, -511,  511, -512, 4'b1010});
        tbl.push_back('{OP_SHL,  256,    1,  511, 4'b1000});
        tbl.push_back('{OP_SHL,    1,   12,  511, 4'b1000});
`else
        tbl.push_back('{OP_ADD,  511,  511,   -2, 4'b1010});
        tbl.push_back('{OP_ADD, -511, -511,    2, 4'b1100});
        tbl.push_back('{OP_SUB,  511, -511,   -2, 4'b1110});
        tbl.push_back('{OP_SUB, -511,  511,    2, 4'b1000});
        tbl.push_back('{OP_SHL,  256,    1, -512, 4'b1010});
        tbl.push_back('{OP_SHL,    1,   12,    0, 4'b1001});
`endif
        tbl.push_back('{OP_SUB,  200, -100,  300, 4'b0100});
        tbl.push_back('{OP_SUB, -200,  100, -300, 4'b0010});
        tbl.push_back('{OP_SUB,  200,  300, -100, 4'b0110});
        tbl.push_back('{OP_SUB, -200, -300,  100, 4'b0000});
        tbl.push_back('{OP_SHR,   -4,    1,   -2, 4'b0010});
        tbl.push_back('{OP_SHR,    3,    1,    1, 4'b0100});
        tbl.push_back('{OP_SHR, -300,   15,   -1, 4'b0110});
        tbl.push_back('{OP_SHR,  100,   10,    0, 4'b0001});
        tbl.push_back('{OP_SHL,   -1,    9, -512, 4'b0110});
        tbl.push_back('{OP_SHL,    3,   17,    6, 4'b0000});
        tbl.push_back('{OP_ADD,   -1,    1,    0, 4'b0101});
        tbl.push_back('{OP_XNOR,   0,    0,   -1, 4'b0010});

        // Reset asserted with valid high: operation discarded, outputs cleared.
        repeat (2) @(posedge clk);
        @(negedge clk);
        valid = 1'b1; op = OP_ADD; a = W'(100); b = W'(100);
        @(posedge clk); #1;
        chk_out("reset", 1'b0, '0, 4'b0000);

        // First op straight after release, then hold while valid is low.
        @(negedge clk);
        rst = 1'b0; valid = 1'b1; op = OP_ADD; a = W'(64); b = W'(16);
        @(negedge clk);
        chk_out("first_after_reset", 1'b1, W'(80), 4'b0000);
        valid = 1'b0; op = OP_SUB; a = W'(5); b = W'(9);
        @(negedge clk);
        chk_out("hold", 1'b0, W'(80), 4'b0000);

        // Back-to-back ops, then reset mid-stream with valid still high.
        valid = 1'b1; op = OP_ADD; a = W'(1); b = W'(2);
        @(negedge clk);
        chk_out("b2b_0", 1'b1, W'(3), 4'b0000);
        op = OP_SUB; a = W'(10); b = W'(3);
        @(negedge clk);
        chk_out("b2b_1", 1'b1, W'(7), 4'b0000);
        rst = 1'b1; op = OP_ADD; a = W'(-100); b = W'(-100);
        @(negedge clk);
        chk_out("mid_reset", 1'b0, '0, 4'b0000);
        rst = 1'b0; op = OP_ADD; a = W'(7); b = W'(8);
        @(negedge clk);
        chk_out("after_mid_reset", 1'b1, W'(15), 4'b0000);

        // Vector table, applied back-to-back.
        for (int i = 0; i < tbl.size(); i++) begin
            op = tbl[i].op; a = W'(tbl[i].a); b = W'(tbl[i].b); valid = 1'b1;
            @(negedge clk);
            chk_out($sformatf("vec%0d", i), 1'b1, W'(tbl[i].er), tbl[i].ef);
        end

        // Randomized traffic with sporadic idle cycles and resets.
        begin
            logic         m_valid = 1'b0;
            logic [W-1:0] m_res = '0;
            logic [3:0]   m_flag = '0;
            logic [W+3:0] m;
            logic [W+4:0] e;
            rst = 1'b1; valid = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i <= 3000; i++) begin
                if (i > 0) begin
                    if (exp_q.size() == 0) begin
                        chk("rand.queue_empty", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk_out($sformatf("rand%0d", i), e[W+4], e[W-1:0], e[W+3:W]);
                    end
                end
                if (i == 3000) break;
                rst   = ($urandom_range(0, 99) < 3);
                valid = ($urandom_range(0, 4) != 0);
                op    = 3'($urandom_range(0, 7));
                a     = pick_operand();
                b     = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : pick_operand();
                if (rst) begin
                    m_valid = 1'b0; m_res = '0; m_flag = '0;
                end else begin
                    m_valid = valid;
                    if (valid) begin
                        m = model(op, a, b);
                        m_res = m[W-1:0]; m_flag = m[W+3:W];
                    end
                end
                exp_q.push_back({m_valid, m_flag, m_res});
                @(negedge clk);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
